// File: rtl/instruction_cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
package instruction_cache_pkg;

  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned NUM_BLOCKS      = 8;
  localparam int unsigned WORDS_PER_BLOCK = 4;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned INDEX_W    = 3;
  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned BLOCK_W    = WORDS_PER_BLOCK * WORD_W;
  localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic {
    StIdle    = 1'b0,
    StMemRead = 1'b1
  } state_e;

endpackage

// File: rtl/instruction_cache_word_select.sv
// Combinational 4:1 selection of one 32-bit word out of a 128-bit cache line.
module icache_word_select
  import instruction_cache_pkg::*;
(
  input  logic [BLOCK_W-1:0] line,
  input  logic [1:0]         word_sel,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word = '0;
    unique case (word_sel)
      2'd0: word = line[0*WORD_W +: WORD_W];
      2'd1: word = line[1*WORD_W +: WORD_W];
      2'd2: word = line[2*WORD_W +: WORD_W];
      2'd3: word = line[3*WORD_W +: WORD_W];
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with block refill from a multi-cycle memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_W-1:0]     PC,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]     HIT_COUNT,
  output logic [STAT_W-1:0]     MISS_COUNT
`endif
);

  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] pc_index;
  logic [1:0]         pc_word;
  logic               unused_pc_bits;

  assign pc_tag         = PC[OFFSET_W+INDEX_W +: TAG_W];
  assign pc_index       = PC[OFFSET_W +: INDEX_W];
  assign pc_word        = PC[2 +: 2];
  assign unused_pc_bits = ^PC[1:0];

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] blk_q;
  logic                  latch_en;
  logic                  fill;
  logic                  hit;
  logic [WORD_W-1:0]     sel_word;

  logic [INDEX_W-1:0]    fill_index;
  logic [TAG_W-1:0]      fill_tag;

  assign fill_index = blk_q[INDEX_W-1:0];
  assign fill_tag   = blk_q[MEM_ADDR_W-1:INDEX_W];

  assign hit = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

  icache_word_select u_word_select (
    .line     (data_q[pc_index]),
    .word_sel (pc_word),
    .word     (sel_word)
  );

  always_comb begin
    state_d     = state_q;
    latch_en    = 1'b0;
    fill        = 1'b0;
    INSTRUCTION = '0;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          INSTRUCTION = sel_word;
        end else begin
          BUSYWAIT = 1'b1;
          latch_en = 1'b1;
          state_d  = StMemRead;
        end
      end
      StMemRead: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = blk_q;
        if (!MEM_BUSYWAIT) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset dominates asynchronously: quiet the CPU and memory interfaces at once.
    if (RESET) begin
      INSTRUCTION = '0;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      fill        = 1'b0;
      latch_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      valid_q <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        blk_q <= {pc_tag, pc_index};
      end
      if (fill) begin
        valid_q[fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage are deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[fill_index] <= MEM_READDATA;
      tag_q[fill_index]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [STAT_W-1:0] hit_count_q, miss_count_q;
  logic              count_hit, count_miss;

  assign count_hit  = (state_q == StIdle) && hit;
  assign count_miss = (state_q == StIdle) && (state_d == StMemRead);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (count_hit && (hit_count_q != {STAT_W{1'b1}})) begin
        hit_count_q <= hit_count_q + 1'b1;
      end
      if (count_miss && (miss_count_q != {STAT_W{1'b1}})) begin
        miss_count_q <= miss_count_q + 1'b1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised bench for instruction_cache against a per-line valid/tag model,
// with a memory whose block contents equal their own byte addresses.
module tb_instruction_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   pc = '0;
  logic [31:0]  instr;
  logic         busy;
  logic         mem_read;
  logic [5:0]   mem_addr;
  logic [127:0] mem_data = '0;
  logic         mem_busy = 1'b1;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int lat        = 5;
  int served     = 0;

  // Model: which tag each line holds, and whether a refill is outstanding.
  bit          m_valid [8];
  logic [2:0]  m_tag   [8];
  bit          m_reading = 1'b0;
  logic [5:0]  m_blk     = '0;
  logic [31:0] m_hits    = '0;
  logic [31:0] m_misses  = '0;

  instruction_cache dut (
    .CLK          (clk),
    .RESET        (rst),
    .PC           (pc),
    .INSTRUCTION  (instr),
    .BUSYWAIT     (busy),
    .MEM_READ     (mem_read),
    .MEM_ADDRESS  (mem_addr),
    .MEM_READDATA (mem_data),
    .MEM_BUSYWAIT (mem_busy)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] blk_data(input logic [5:0] b);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      d[i*32 +: 32] = {22'h0, b, w, 2'b00};
    end
    return d;
  endfunction

  // Per-cycle compare, memory responder and model update, away from the active edge.
  always @(negedge clk) begin
    logic [2:0] idx;
    logic [2:0] tg;
    bit         cur_reading;
    bit         hit;
`ifdef ICACHE_STATS_EN
    check("hit_count", {16'h0, hit_count}, rst ? 32'h0 : m_hits);
    check("miss_count", {16'h0, miss_count}, rst ? 32'h0 : m_misses);
`endif
    if (rst) begin
      check("rst_busywait", {31'h0, busy}, 32'h0);
      check("rst_mem_read", {31'h0, mem_read}, 32'h0);
      check("rst_instruction", instr, 32'h0);
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_reading = 1'b0;
      m_hits    = '0;
      m_misses  = '0;
      served    = 0;
      mem_busy  = 1'b1;
    end else begin
      idx         = pc[6:4];
      tg          = pc[9:7];
      cur_reading = m_reading;
      hit         = !cur_reading && m_valid[idx] && (m_tag[idx] == tg);
      if (!cur_reading) begin
        check("idle_busywait", {31'h0, busy}, {31'h0, !hit});
        check("idle_mem_read", {31'h0, mem_read}, 32'h0);
        check("idle_mem_address", {26'h0, mem_addr}, 32'h0);
        check("idle_instruction", instr, hit ? {22'h0, pc[9:2], 2'b00} : 32'h0);
      end else begin
        check("fill_busywait", {31'h0, busy}, 32'h1);
        check("fill_mem_read", {31'h0, mem_read}, 32'h1);
        check("fill_mem_address", {26'h0, mem_addr}, {26'h0, m_blk});
      end
      if (mem_read) begin
        mem_busy = (served < lat);
        mem_data = blk_data(mem_addr);
        served++;
      end else begin
        served   = 0;
        mem_busy = 1'b1;
      end
      if (!cur_reading) begin
        if (hit) begin
          if (m_hits < 32'hFFFF) m_hits++;
        end else begin
          m_reading = 1'b1;
          m_blk     = {tg, idx};
          if (m_misses < 32'hFFFF) m_misses++;
        end
      end else if (!mem_busy) begin
        m_valid[m_blk[2:0]] = 1'b1;
        m_tag[m_blk[2:0]]   = m_blk[5:3];
        m_reading           = 1'b0;
      end
    end
  end

  // CPU-side fetch: hold PC until BUSYWAIT is low; starts and ends at posedge+1.
  task automatic fetch(input logic [9:0] a, output logic [31:0] got, output int cyc,
                       output logic [5:0] maddr);
    bit done;
    pc    = a;
    cyc   = 0;
    maddr = '0;
    got   = '0;
    done  = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        got  = instr;
        done = 1'b1;
      end else begin
        cyc++;
        if (mem_read) maddr = mem_addr;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check("fetch_timeout", 32'h1, 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int          cyc;
    logic [5:0]  maddr;
    logic [31:0] r;
    logic [9:0]  nxt;

    do_reset();

    // Cold miss with a 5-busy-cycle memory.
    lat = 5;
    fetch(10'h000, got, cyc, maddr);
    check("cold_miss_cycles", cyc, 32'd7);
    check("cold_miss_addr", {26'h0, maddr}, 32'h0);
    check("cold_miss_instr", got, 32'h0);

    // Spatial hits in the same line.
    fetch(10'h004, got, cyc, maddr);
    check("hit4_instr", got, 32'h4);
    check("hit4_cycles", cyc, 32'd0);
    fetch(10'h008, got, cyc, maddr);
    check("hit8_instr", got, 32'h8);
    check("hit8_cycles", cyc, 32'd0);
    fetch(10'h00C, got, cyc, maddr);
    check("hitC_instr", got, 32'hC);
    check("hitC_cycles", cyc, 32'd0);

    // Index conflict on line 0.
    fetch(10'h080, got, cyc, maddr);
    check("conflict1_addr", {26'h0, maddr}, 32'h08);
    check("conflict1_instr", got, 32'h80);
    check("conflict1_cycles", cyc, 32'd7);
    fetch(10'h000, got, cyc, maddr);
    check("conflict2_addr", {26'h0, maddr}, 32'h00);
    check("conflict2_instr", got, 32'h0);
    check("conflict2_cycles", cyc, 32'd7);

    // Reset during the third MEM_READ cycle of a miss.
    pc = 10'h100;
    repeat (3) @(posedge clk);
    #1;
    check("midfill_mem_read_before", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    #1;
    check("midfill_mem_read_drop", {31'h0, mem_read}, 32'h0);
    check("midfill_busywait_drop", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fetch(10'h000, got, cyc, maddr);
    check("post_reset_miss_cycles", cyc, 32'd7);
    check("post_reset_instr", got, 32'h0);

    // Zero-latency memory: miss costs exactly two stall cycles.
    lat = 0;
    fetch(10'h01C, got, cyc, maddr);
    check("zero_lat_cycles", cyc, 32'd2);
    check("zero_lat_instr", got, 32'h1C);
    check("zero_lat_addr", {26'h0, maddr}, 32'h01);

    // Randomised fetch stream, mostly sequential, over four tags.
    for (int n = 0; n < 400; n++) begin
      r   = $urandom();
      lat = int'(r[13:12]);
      if (r[0]) nxt = pc + 10'd4;
      else      nxt = {1'b0, r[2:1], r[5:3], r[7:6], 2'b00};
      fetch(nxt, got, cyc, maddr);
      check("rand_instr", got, {22'h0, nxt[9:2], 2'b00});
    end

`ifdef ICACHE_STATS_EN
    do_reset();
    lat = 1;
    fetch(10'h200, got, cyc, maddr);
    fetch(10'h204, got, cyc, maddr);
    fetch(10'h208, got, cyc, maddr);
    check("stats_hits_a", {16'h0, hit_count}, 32'd3);
    check("stats_misses_a", {16'h0, miss_count}, 32'd1);
    fetch(10'h210, got, cyc, maddr);
    check("stats_hits_b", {16'h0, hit_count}, 32'd4);
    check("stats_misses_b", {16'h0, miss_count}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
